// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM encodings and helpers for the BCD-to-binary converter
package bcd_pkg;

    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] INIT  = 3'b001;
    localparam logic [2:0] SHIFT = 3'b011;
    localparam logic [2:0] CHECK = 3'b010;
    localparam logic [2:0] FIN   = 3'b110;

    localparam int BCD_BIN_W = 14;
    localparam int CNT_W     = $clog2(BCD_BIN_W + 1);

    function automatic logic bcd_digit_valid(input logic [3:0] nibble);
        return nibble <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - per-digit correction step of reverse double-dabble
module bcd_digit_sub3 (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // After a right shift a digit >= 8 carried in a half-ten; remove it.
    assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to binary converter (shift right, correct digits)
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   BCDIN,
    output logic [BIN_W-1:0]      BINOUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int SR_W = 4*DIGITS + BIN_W;
    localparam int CW   = $clog2(BIN_W + 1);

    logic [2:0]          state_q, state_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]    binout_q, binout_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [4*DIGITS-1:0] corr;
    logic                any_bad;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .d_i (sr_q[BIN_W + 4*g +: 4]),
            .d_o (corr[4*g +: 4])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(BCDIN[4*i +: 4])) any_bad = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        binout_d = binout_q;
        done_d   = done_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (START) state_d = INIT;
            end
            INIT: begin
                sr_d  = {BCDIN, {BIN_W{1'b0}}};
                cnt_d = '0;
                if (any_bad) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    err_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d    = sr_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                sr_d    = {corr, sr_q[BIN_W-1:0]};
                state_d = (cnt_q == CW'(BIN_W)) ? FIN : SHIFT;
            end
            FIN: begin
                if (!err_q) binout_d = sr_q[BIN_W-1:0];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            binout_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            binout_q <= binout_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign BINOUT = binout_q;
    assign BUSY   = (state_q != IDLE);
    assign DONE   = done_q;
    assign ERR    = err_q;

    // A valid input has been fully drained out of the digit field by the last correction.
    a_bcd_drained: assert property (@(posedge CLK) disable iff (!RST)
        (state_q == FIN && !err_q) |-> (sr_q[SR_W-1:BIN_W] == '0));

endmodule
